// File: rtl/bclk_training_ctrl.sv
// BCLK training sequencer for the DDR4 IOD lane.
// Sweeps the RX delay line, finds the first BCLK edge, parks past it.
module bclk_training_ctrl #(
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int OFFSET_TAPS   = 16
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       delay_oor,
  input  logic       eye_early,
  input  logic       eye_late,
  output logic       dl_load,
  output logic       dl_move,
  output logic       dl_dir,
  output logic       em_clear,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] edge_tap,
  output logic [7:0] final_tap,
  output logic [1:0] eye_flags
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL,
    S_DIR, S_MOVE, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] LP_MAX  = 8'(MAX_TAP);
  localparam logic [7:0] LP_SLST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LP_SCLR = 8'(SETTLE_CYCLES - 2);
  localparam logic [7:0] LP_MLST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] LP_OFS  = 8'(OFFSET_TAPS);

  state_t     r_state;
  logic [7:0] r_tap;
  logic [7:0] r_cnt;
  logic [7:0] r_cur;
  logic [7:0] r_ref;
  logic [7:0] r_rem;
  logic [7:0] r_edge_tap;
  logic [7:0] r_final_tap;
  logic [1:0] r_eye;
  logic       r_unstable;
  logic       r_adj;
  logic       r_load;
  logic       r_move;
  logic       r_dir;
  logic       r_clr;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  logic       w_edge;
  logic       w_active;
  logic [8:0] w_reach;
  logic [7:0] w_tap_inc;

  assign w_edge    = r_unstable || (r_cur != r_ref);
  assign w_reach   = {1'b0, r_tap} + {1'b0, LP_OFS};
  assign w_tap_inc = (r_tap >= LP_MAX) ? LP_MAX : r_tap + 8'd1;
  assign w_active  = (r_state != S_IDLE) &&
                     (r_state != S_DONE) &&
                     (r_state != S_ERR);

  assign dl_load   = r_load;
  assign dl_move   = r_move;
  assign dl_dir    = r_dir;
  assign em_clear  = r_clr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_err;
  assign edge_tap  = r_edge_tap;
  assign final_tap = r_final_tap;
  assign eye_flags = r_eye;

  // Sweep / evaluate / adjust sequencer with registered lane controls
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_ref       <= '0;
      r_rem       <= '0;
      r_edge_tap  <= '0;
      r_final_tap <= '0;
      r_eye       <= '0;
      r_unstable  <= 1'b0;
      r_adj       <= 1'b0;
      r_load      <= 1'b0;
      r_move      <= 1'b0;
      r_dir       <= 1'b0;
      r_clr       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_active && delay_oor) begin
      r_load      <= 1'b0;
      r_move      <= 1'b0;
      r_clr       <= 1'b0;
      r_err       <= 1'b1;
      r_busy      <= 1'b0;
      r_final_tap <= r_tap;
      r_state     <= S_ERR;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_load      <= 1'b1;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_edge_tap  <= '0;
            r_final_tap <= '0;
            r_eye       <= '0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_load  <= 1'b0;
          r_tap   <= '0;
          r_cnt   <= '0;
          r_adj   <= 1'b0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == LP_SLST) begin
            r_clr <= 1'b0;
            r_cnt <= '0;
            if (!r_adj) begin
              r_state <= S_SAMPLE;
            end else if (r_rem == '0) begin
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_final_tap <= r_tap;
              r_state     <= S_DONE;
            end else begin
              r_dir   <= 1'b1;
              r_state <= S_DIR;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == LP_SCLR) r_clr <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (r_cnt == '0) begin
            r_cur      <= rx_data;
            r_unstable <= 1'b0;
            r_eye      <= {eye_early, eye_late};
          end else begin
            if (rx_data != r_cur) r_unstable <= 1'b1;
            r_eye <= r_eye | {eye_early, eye_late};
          end
          if (r_cnt == LP_MLST) begin
            r_cnt   <= '0;
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EVAL: begin
          if (r_tap == '0 && r_unstable) begin
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_final_tap <= r_tap;
            r_state     <= S_ERR;
          end else if (r_tap == '0) begin
            r_ref   <= r_cur;
            r_dir   <= 1'b1;
            r_state <= S_DIR;
          end else if (w_edge) begin
            r_edge_tap <= r_tap;
            if (w_reach > {1'b0, LP_MAX}) begin
              r_err       <= 1'b1;
              r_busy      <= 1'b0;
              r_final_tap <= r_tap;
              r_state     <= S_ERR;
            end else begin
              r_rem   <= LP_OFS;
              r_adj   <= 1'b1;
              r_dir   <= 1'b1;
              r_state <= S_DIR;
            end
          end else if (r_tap >= LP_MAX) begin
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_final_tap <= r_tap;
            r_state     <= S_ERR;
          end else begin
            r_dir   <= 1'b1;
            r_state <= S_DIR;
          end
        end
        S_DIR: begin
          r_move  <= 1'b1;
          r_tap   <= w_tap_inc;
          if (r_adj) r_rem <= r_rem - 8'd1;
          r_state <= S_MOVE;
        end
        S_MOVE: begin
          r_move  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
